// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module      : y86_pkg
// Description : Shared Y86 constants: datapath width, register count,
//               special register IDs and ALU function codes.
// Revision    : 1.0 - initial release
// ============================================================================
package y86_pkg;

  // Datapath width and number of architectural registers (IDs 0..14)
  localparam int DATA_W = 64;
  localparam int NREG   = 15;

  // Special register IDs
  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  // ALU function codes (ifun field of OPq)
  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_XOR = 4'h3
  } alu_fn_e;

endpackage
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : Y86 architectural register file. Two combinational read
//               ports plus a debug read port, two write ports (E and M)
//               committed on the rising edge, with M taking priority when
//               both target the same register. Counts committed writes.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file #(
  parameter int         DATA_W = y86_pkg::DATA_W,
  parameter int         NREG   = y86_pkg::NREG,
  parameter logic [3:0] RNONE  = y86_pkg::RNONE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  input  logic [3:0]        dstE,
  input  logic [DATA_W-1:0] valE,
  input  logic [3:0]        dstM,
  input  logic [DATA_W-1:0] valM,
  input  logic              wr_en,
  input  logic [3:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_val,
  output logic [15:0]       wr_count
);

  // Register count as a 5-bit value so any 4-bit ID can be range-checked
  localparam logic [4:0] c_nreg = 5'(NREG);

  logic [DATA_W-1:0] r_regs [NREG];
  logic [15:0]       r_wr_count;

  logic              w_we_e;
  logic              w_we_m;
  logic              w_same;
  logic [1:0]        w_inc;

  // An ID names real storage only if it is not RNONE and within range
  function automatic logic id_valid(input logic [3:0] id);
    return (id != RNONE) && ({1'b0, id} < c_nreg);
  endfunction

  // Combinational reads from stored state; invalid IDs read as zero
  always_comb begin
    valA    = '0;
    valB    = '0;
    dbg_val = '0;
    if (id_valid(srcA))    valA    = r_regs[srcA];
    if (id_valid(srcB))    valB    = r_regs[srcB];
    if (id_valid(dbg_sel)) dbg_val = r_regs[dbg_sel];
  end

  // Write decode: a same-ID dual write touches one register, so counts once
  always_comb begin
    w_we_e = wr_en && id_valid(dstE);
    w_we_m = wr_en && id_valid(dstM);
    w_same = w_we_e && w_we_m && (dstE == dstM);
    w_inc  = {1'b0, w_we_e} + {1'b0, w_we_m} - {1'b0, w_same};
  end

  // Register storage; M port listed first so it wins on a shared ID
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (w_we_m && (dstM == 4'(i))) begin
          r_regs[i] <= valM;
        end else if (w_we_e && (dstE == 4'(i))) begin
          r_regs[i] <= valE;
        end
      end
    end
  end

  // Committed-write counter, wraps naturally modulo 2^16
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_count <= '0;
    end else begin
      r_wr_count <= r_wr_count + 16'(w_inc);
    end
  end

  assign wr_count = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file
// Description : Scoreboard bench for register_file. Stimulus pushes expected
//               values into a queue; a monitor pops and compares them
//               against the selected DUT output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file;

  localparam logic [3:0] c_rnone = 4'hF;

  logic        clk;
  logic        clk_run;
  logic        reset;
  logic [3:0]  srcA, srcB, dstE, dstM, dbg_sel;
  logic [63:0] valA, valB, valE, valM, dbg_val;
  logic        wr_en;
  logic [15:0] wr_count;

  typedef struct {
    string       name;
    int          sel;   // 0 valA, 1 valB, 2 dbg_val, 3 wr_count
    logic [63:0] exp;
  } exp_t;

  exp_t sb_q[$];
  event e_chk;
  int   n_tests;
  int   n_fail;

  register_file dut (
    .clk     (clk),
    .reset   (reset),
    .srcA    (srcA),
    .srcB    (srcB),
    .valA    (valA),
    .valB    (valB),
    .dstE    (dstE),
    .valE    (valE),
    .dstM    (dstM),
    .valM    (valM),
    .wr_en   (wr_en),
    .dbg_sel (dbg_sel),
    .dbg_val (dbg_val),
    .wr_count(wr_count)
  );

  // Pausable clock: period 10, stays at its level while clk_run is low
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  // Monitor: drain every queued expectation against the live DUT outputs
  initial begin
    exp_t        e;
    logic [63:0] act;
    forever begin
      @(e_chk);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        case (e.sel)
          0:       act = valA;
          1:       act = valB;
          2:       act = dbg_val;
          default: act = {48'h0, wr_count};
        endcase
        n_tests++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int sel, input logic [63:0] exp);
    sb_q.push_back('{nm, sel, exp});
    -> e_chk;
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0;
    dstE  = c_rnone;
    dstM  = c_rnone;
    valE  = '0;
    valM  = '0;
  endtask

  // One write cycle: drive after the falling edge, commit on the rising edge
  task automatic write_cycle(input logic we, input logic [3:0] de, input logic [63:0] ve,
                             input logic [3:0] dm, input logic [63:0] vm);
    @(negedge clk);
    wr_en = we; dstE = de; valE = ve; dstM = dm; valM = vm;
    @(posedge clk);
    #1;
    idle();
  endtask

  // Debug sweep of every register with the clock held low
  task automatic sweep(input string nm, input logic [63:0] expv [15]);
    @(negedge clk);
    clk_run = 1'b0;
    #1;
    for (int i = 0; i < 15; i++) begin
      dbg_sel = 4'(i);
      #1;
      check($sformatf("%s_r%0d", nm, i), 2, expv[i]);
    end
    clk_run = 1'b1;
  endtask

  initial begin
    logic [63:0] exp_regs [15];

    n_tests = 0;
    n_fail  = 0;
    clk_run = 1'b1;
    reset   = 1'b1;
    srcA    = 4'd0;
    srcB    = 4'd0;
    dbg_sel = 4'd0;
    idle();

    // Writes attempted while reset is held must be ignored
    #2;
    check("rst_wr_count", 3, 64'h0);
    check("rst_valA", 0, 64'h0);
    write_cycle(1'b1, 4'd1, 64'h77, 4'd6, 64'h66);
    srcA = 4'd1; srcB = 4'd6;
    #1;
    check("rst_ignore_r1", 0, 64'h0);
    check("rst_ignore_r6", 1, 64'h0);

    @(negedge clk);
    reset = 1'b0;

    // No bypass: old value before the edge, new value after
    @(negedge clk);
    srcA = 4'd3; wr_en = 1'b1; dstE = 4'd3; valE = 64'h1234;
    #1;
    check("nobypass_old", 0, 64'h0);
    @(posedge clk);
    #1;
    idle();
    check("wr_new_valA", 0, 64'h1234);
    check("wr_count_1", 3, 64'd1);

    // Same-ID dual write: M wins, counted once
    write_cycle(1'b1, 4'd4, 64'hA0, 4'd4, 64'hB0);
    dbg_sel = 4'd4;
    #1;
    check("dual_same_r4", 2, 64'hB0);
    check("dual_same_cnt", 3, 64'd2);

    // Distinct dual write: both land, counted twice
    write_cycle(1'b1, 4'd2, 64'd5, 4'd7, 64'd9);
    srcA = 4'd2; srcB = 4'd7;
    #1;
    check("dual_r2", 0, 64'd5);
    check("dual_r7", 1, 64'd9);
    check("dual_cnt", 3, 64'd4);

    // Write enable low: nothing changes
    write_cycle(1'b0, 4'd1, 64'hFF, 4'd6, 64'hEE);
    srcA = 4'd1; srcB = 4'd6;
    #1;
    check("wren0_r1", 0, 64'h0);
    check("wren0_r6", 1, 64'h0);
    check("wren0_cnt", 3, 64'd4);

    // Writes to RNONE are dropped; RNONE reads zero
    write_cycle(1'b1, c_rnone, 64'hFF, c_rnone, 64'hFE);
    srcA = c_rnone;
    #1;
    check("rnone_valA", 0, 64'h0);
    check("rnone_cnt", 3, 64'd4);
    for (int i = 0; i < 15; i++) exp_regs[i] = '0;
    exp_regs[2] = 64'd5;
    exp_regs[3] = 64'h1234;
    exp_regs[4] = 64'hB0;
    exp_regs[7] = 64'd9;
    sweep("rnone", exp_regs);

    // Mid-run reset with a pending write: immediate clear, write discarded
    @(negedge clk);
    clk_run = 1'b0;
    wr_en = 1'b1; dstE = 4'd5; valE = 64'h55;
    #1;
    reset = 1'b1;
    #1;
    srcA = 4'd3;
    #1;
    check("async_rst_cnt", 3, 64'h0);
    check("async_rst_valA", 0, 64'h0);
    for (int i = 0; i < 15; i++) begin
      dbg_sel = 4'(i);
      #1;
      check($sformatf("async_rst_r%0d", i), 2, 64'h0);
    end
    clk_run = 1'b1;
    @(posedge clk);
    #1;
    dbg_sel = 4'd5;
    #1;
    check("rst_pending_drop", 2, 64'h0);
    check("rst_pending_cnt", 3, 64'h0);

    // First edge after reset release writes normally
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    idle();
    check("post_rst_r5", 2, 64'h55);
    check("post_rst_cnt", 3, 64'd1);

    // Fill the counter up to 16'hFFFF, then wrap
    for (int i = 0; i < 65534; i++) begin
      write_cycle(1'b1, 4'(i % 15), 64'(i), c_rnone, 64'h0);
    end
    check("cnt_ffff", 3, 64'hFFFF);
    write_cycle(1'b1, 4'd0, 64'hDEAD, c_rnone, 64'h0);
    dbg_sel = 4'd0;
    #1;
    check("cnt_wrap", 3, 64'h0);
    check("wrap_r0", 2, 64'hDEAD);
    write_cycle(1'b1, 4'd8, 64'h8, 4'd9, 64'h9);
    check("cnt_after_wrap", 3, 64'd2);

    #2;
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, meaning register and data-port width in bits.
REQ-002 The block SHALL have parameter NREG, default 15, meaning number of architectural registers, IDs 0..14.
REQ-003 The block SHALL have parameter RNONE, default 4'hF, meaning the "no register" ID.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port srcA, input, 4, read-port A register ID.
REQ-007 The block SHALL have port srcB, input, 4, read-port B register ID.
REQ-008 The block SHALL have port valA, output, DATA_W, read-port A data, forwarded to the ALU B/A operand path.
REQ-009 The block SHALL have port valB, output, DATA_W, read-port B data.
REQ-010 The block SHALL have port dstE, input, 4, destination ID for the ALU result.
REQ-011 The block SHALL have port valE, input, DATA_W, ALU result (the adder/logic output).
REQ-012 The block SHALL have port dstM, input, 4, destination ID for the memory result.
REQ-013 The block SHALL have port valM, input, DATA_W, memory read data.
REQ-014 The block SHALL have port wr_en, input, 1, global write enable; deasserted when processor status is not AOK.
REQ-015 The block SHALL have port dbg_sel, input, 4, debug read register ID.
REQ-016 The block SHALL have port dbg_val, output, DATA_W, debug read data.
REQ-017 The block SHALL have port wr_count, output, 16, count of committed register writes since reset.

Function
REQ-018 Reads SHALL be combinational from current stored state; valA = reg[srcA], valB = reg[srcB], dbg_val = reg[dbg_sel].
REQ-019 A read of ID RNONE SHALL return 0 on that port.
REQ-020 A read in the same cycle as a write to that ID SHALL return the old value: no write-through bypass. The new value is visible after the edge.
REQ-021 On a rising edge with wr_en=1 and dstE != RNONE, reg[dstE] SHALL load valE.
REQ-022 On a rising edge with wr_en=1 and dstM != RNONE, reg[dstM] SHALL load valM.
REQ-023 If dstE == dstM != RNONE with wr_en=1, valM SHALL win (popq %rsp rule).
REQ-024 With wr_en=0, no register SHALL change regardless of dstE/dstM.
REQ-025 A write addressed to RNONE SHALL be dropped with no side effect.
REQ-026 wr_count SHALL increment once per edge for each distinct register actually written.
REQ-027 Per REQ-026, the increment is 0, 1 or 2; a same-ID dual write counts 1.
REQ-028 wr_count SHALL wrap from 16'hFFFF to 0 modulo 2^16.
REQ-029 Read and write latency SHALL be: reads 0 cycles; writes 1 edge.

Reset
REQ-030 Asserting reset SHALL immediately, without waiting for clk, clear all NREG registers and wr_count to 0. As a result valA, valB and dbg_val read 0.
REQ-031 While reset is high, writes SHALL be ignored.
REQ-032 After reset deasserts, the first rising edge SHALL perform writes normally.
REQ-033 Reset asserted mid-cycle while a write is pending SHALL discard that write.

Structure
REQ-034 Register IDs (RRSP=4, RNONE=15), DATA_W and NREG SHALL live in shared package y86_pkg, alongside the ALU function codes.
REQ-035 The block SHALL be a single module with no sub-module; storage is an array of NREG DATA_W-bit registers plus write-decode logic.

Verification
REQ-036 Bench SHALL pulse reset mid-run, then read all IDs 0..14 via dbg_sel; required response: every dbg_val = 0 and wr_count = 0 immediately, before any clk edge.
REQ-037 Bench SHALL drive dstE=3, valE=64'h1234, wr_en=1 with srcA=3 in the same cycle; required response: valA reads old value 0 before the edge and 64'h1234 after; wr_count = 1.
REQ-038 Bench SHALL drive dstE=4, valE=64'hA0, dstM=4, valM=64'hB0 in one edge; required response: reg4 = 64'hB0 and wr_count +1.
REQ-039 Bench SHALL drive dstE=2, valE=5, dstM=7, valM=9 in one edge; required response: reg2 = 5, reg7 = 9, wr_count +2.
REQ-040 Bench SHALL drive wr_en=0 with dstE=1, valE=64'hFF; required response: reg1 unchanged. A second case drives dstE=RNONE; required response: no register changes and srcA=RNONE reads 0.
REQ-041 Bench SHALL preload wr_count to 16'hFFFF via 65535 writes, then perform one write; required response: wr_count = 0.
